// File: rtl/cylon_ctrl_panel.sv
`default_nettype none
// ============================================================================
//  Module      : cylon_ctrl_panel
//  Description : Four-button control panel (mode, select, up, down) with
//                synchronizers, debouncers and up/down auto-repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module cylon_ctrl_panel #(
    parameter int DEBOUNCE_CLKS     = 1_000_000,
    parameter int REPEAT_DELAY_CLKS = 50_000_000,
    parameter int REPEAT_RATE_CLKS  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] mode,
    output logic [3:0] speed,
    output logic [3:0] brightness,
    output logic       sel,
    output logic       changed
);

    localparam int c_DB_W    = $clog2(DEBOUNCE_CLKS + 1);
    localparam int c_RPT_MAX = (REPEAT_DELAY_CLKS > REPEAT_RATE_CLKS) ?
                               REPEAT_DELAY_CLKS : REPEAT_RATE_CLKS;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(DEBOUNCE_CLKS - 1);
    localparam logic [c_RPT_W-1:0] c_DELAY_LAST = c_RPT_W'(REPEAT_DELAY_CLKS - 1);
    localparam logic [c_RPT_W-1:0] c_RATE_LAST  = c_RPT_W'(REPEAT_RATE_CLKS - 1);

    localparam int c_B_MODE = 0;
    localparam int c_B_SEL  = 1;
    localparam int c_B_UP   = 2;
    localparam int c_B_DOWN = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [3:0] w_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_deb;
    logic [3:0] r_deb_q;
    logic [3:0] w_press;

    assign w_raw = {btn_down, btn_up, btn_sel, btn_mode};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_q <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= w_deb;
        end
    end

    // One debouncer per button; any return to the accepted level clears the count.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_db
            logic [c_DB_W-1:0] r_cnt;
            logic              r_level;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (r_sync2[gi] != r_level) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_level <= r_sync2[gi];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DB_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_deb[gi] = r_level;
        end
    endgenerate

    assign w_press = w_deb & ~r_deb_q;

    state_t             r_state;
    state_t             w_state_nx;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic [c_RPT_W-1:0] w_rpt_cnt_nx;
    logic               r_tgt;
    logic               w_tgt_nx;
    logic               r_dir_up;
    logic               w_dir_up_nx;
    logic               w_step;
    logic               w_held;

    logic [1:0] r_mode;
    logic [3:0] r_speed;
    logic [3:0] r_bright;
    logic       r_sel;
    logic       r_changed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
            r_tgt     <= 1'b0;
            r_dir_up  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_rpt_cnt <= w_rpt_cnt_nx;
            r_tgt     <= w_tgt_nx;
            r_dir_up  <= w_dir_up_nx;
        end
    end

    // A dropped hold behaves as idle so a press arriving in that cycle is kept.
    always_comb begin
        w_state_nx   = r_state;
        w_rpt_cnt_nx = r_rpt_cnt;
        w_tgt_nx     = r_tgt;
        w_dir_up_nx  = r_dir_up;
        w_step       = 1'b0;
        w_held       = r_dir_up ? w_deb[c_B_UP] : w_deb[c_B_DOWN];

        if (w_deb[c_B_UP] && w_deb[c_B_DOWN]) begin
            w_state_nx   = ST_IDLE;
            w_rpt_cnt_nx = '0;
        end else if (r_state == ST_IDLE || !w_held) begin
            w_state_nx   = ST_IDLE;
            w_rpt_cnt_nx = '0;
            if (w_press[c_B_UP] || w_press[c_B_DOWN]) begin
                w_state_nx  = ST_DELAY;
                w_tgt_nx    = r_sel;
                w_dir_up_nx = w_press[c_B_UP];
                w_step      = 1'b1;
            end
        end else begin
            case (r_state)
                ST_DELAY: begin
                    if (r_rpt_cnt == c_DELAY_LAST) begin
                        w_state_nx   = ST_REPEAT;
                        w_rpt_cnt_nx = '0;
                        w_step       = 1'b1;
                    end else begin
                        w_rpt_cnt_nx = r_rpt_cnt + c_RPT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (r_rpt_cnt == c_RATE_LAST) begin
                        w_rpt_cnt_nx = '0;
                        w_step       = 1'b1;
                    end else begin
                        w_rpt_cnt_nx = r_rpt_cnt + c_RPT_W'(1);
                    end
                end
                default: begin
                    w_state_nx   = ST_IDLE;
                    w_rpt_cnt_nx = '0;
                end
            endcase
        end
    end

    logic [1:0] w_mode_nx;
    logic       w_sel_nx;
    logic [3:0] w_speed_nx;
    logic [3:0] w_bright_nx;
    logic [3:0] w_cur;
    logic [3:0] w_adj;
    logic       w_changed_nx;

    always_comb begin
        w_mode_nx   = w_press[c_B_MODE] ? r_mode + 2'd1 : r_mode;
        w_sel_nx    = r_sel ^ w_press[c_B_SEL];
        w_speed_nx  = r_speed;
        w_bright_nx = r_bright;
        w_cur       = w_tgt_nx ? r_bright : r_speed;
        w_adj       = w_cur;

        if (w_dir_up_nx) begin
            if (w_cur != 4'd15) w_adj = w_cur + 4'd1;
        end else begin
            if (w_cur != 4'd0) w_adj = w_cur - 4'd1;
        end

        if (w_step) begin
            if (w_tgt_nx) w_bright_nx = w_adj;
            else          w_speed_nx  = w_adj;
        end

        w_changed_nx = (w_mode_nx != r_mode) || (w_sel_nx != r_sel) ||
                       (w_speed_nx != r_speed) || (w_bright_nx != r_bright);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= 2'd0;
            r_speed   <= 4'd0;
            r_bright  <= 4'd15;
            r_sel     <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_mode    <= w_mode_nx;
            r_speed   <= w_speed_nx;
            r_bright  <= w_bright_nx;
            r_sel     <= w_sel_nx;
            r_changed <= w_changed_nx;
        end
    end

    assign mode       = r_mode;
    assign speed      = r_speed;
    assign brightness = r_bright;
    assign sel        = r_sel;
    assign changed    = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_cylon_ctrl_panel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cylon_ctrl_panel
//  Description : Directed and random stimulus against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cylon_ctrl_panel;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [1:0] mode;
    logic [3:0] speed;
    logic [3:0] brightness;
    logic       sel;
    logic       changed;

    int n_checks = 0;
    int n_errors = 0;

    cylon_ctrl_panel #(
        .DEBOUNCE_CLKS    (DB),
        .REPEAT_DELAY_CLKS(RD),
        .REPEAT_RATE_CLKS (RR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_sel   (btn_sel),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .mode      (mode),
        .speed     (speed),
        .brightness(brightness),
        .sel       (sel),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: button delay line, stable-run debounce, hold-age repeat.
    int m_s1[4], m_s2[4], m_deb[4], m_prev[4], m_run[4];
    int m_mode, m_speed, m_bright, m_sel, m_changed;
    int m_hold;   // 0 none, 2 up, 3 down
    int m_age, m_tgt;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_prev[b] = 0; m_run[b] = 0;
        end
        m_mode = 0; m_speed = 0; m_bright = 15; m_sel = 0; m_changed = 0;
        m_hold = 0; m_age = 0; m_tgt = 0;
    endtask

    task automatic model_edge();
        int raw[4];
        int d_old[4], s2_old[4], press[4];
        int o_mode, o_speed, o_bright, o_sel, sel_old, step, v;
        if (rst) begin
            model_reset();
            return;
        end
        raw[0] = int'(btn_mode); raw[1] = int'(btn_sel);
        raw[2] = int'(btn_up);   raw[3] = int'(btn_down);
        for (int b = 0; b < 4; b++) begin
            d_old[b]  = m_deb[b];
            s2_old[b] = m_s2[b];
            press[b]  = (m_deb[b] == 1 && m_prev[b] == 0) ? 1 : 0;
        end
        o_mode = m_mode; o_speed = m_speed; o_bright = m_bright; o_sel = m_sel;
        sel_old = m_sel;
        step = 0;
        if (press[0] == 1) m_mode = (m_mode + 1) % 4;
        if (press[1] == 1) m_sel = 1 - m_sel;
        if (d_old[2] == 1 && d_old[3] == 1) begin
            m_hold = 0;
        end else begin
            if (m_hold != 0 && d_old[m_hold] == 0) m_hold = 0;
            if (m_hold != 0) begin
                m_age++;
                if (m_age == RD || (m_age > RD && (m_age - RD) % RR == 0)) step = 1;
            end else if (press[2] == 1 || press[3] == 1) begin
                m_hold = (press[2] == 1) ? 2 : 3;
                m_age  = 0;
                m_tgt  = sel_old;
                step   = 1;
            end
        end
        if (step == 1) begin
            v = (m_tgt == 1) ? m_bright : m_speed;
            if (m_hold == 2) v = (v < 15) ? v + 1 : 15;
            else             v = (v > 0) ? v - 1 : 0;
            if (m_tgt == 1) m_bright = v;
            else            m_speed  = v;
        end
        m_changed = (o_mode != m_mode || o_speed != m_speed ||
                     o_bright != m_bright || o_sel != m_sel) ? 1 : 0;
        for (int b = 0; b < 4; b++) begin
            if (s2_old[b] != d_old[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_deb[b] = s2_old[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
            m_prev[b] = d_old[b];
            m_s2[b]   = m_s1[b];
            m_s1[b]   = raw[b];
        end
    endtask

    task automatic compare_all();
        check_eq("mode", int'(mode), m_mode);
        check_eq("speed", int'(speed), m_speed);
        check_eq("brightness", int'(brightness), m_bright);
        check_eq("sel", int'(sel), m_sel);
        check_eq("changed", int'(changed), m_changed);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_mode", int'(mode), 0);
        check_eq("rst_speed", int'(speed), 0);
        check_eq("rst_bright", int'(brightness), 15);
        check_eq("rst_sel", int'(sel), 0);
        check_eq("rst_changed", int'(changed), 0);
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        run(3);
        rst = 1'b0;
        run(1);
        check_eq("init_mode", int'(mode), 0);
        check_eq("init_bright", int'(brightness), 15);

        // Mode presses: output must land exactly 7 cycles after the raw edge.
        for (int p = 1; p <= 4; p++) begin
            btn_mode = 1'b1;
            run(6);
            check_eq("mode_early", int'(mode), (p - 1) % 4);
            run(1);
            check_eq("mode_latency", int'(mode), p % 4);
            check_eq("mode_changed", int'(changed), 1);
            run(1);
            check_eq("mode_chg_1cyc", int'(changed), 0);
            run(4);
            btn_mode = 1'b0;
            run(10);
        end

        // Bouncy up: never stable long enough to be accepted.
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            run(2);
        end
        btn_up = 1'b0;
        run(12);
        check_eq("bounce_speed", int'(speed), 0);

        // Up held 40 debounced cycles on speed.
        btn_up = 1'b1;
        run(40);
        btn_up = 1'b0;
        run(30);
        check_eq("hold_speed", int'(speed), 5);

        // Brightness target: saturated up, then held down into repeat.
        btn_sel = 1'b1; run(10); btn_sel = 1'b0; run(10);
        check_eq("sel_toggled", int'(sel), 1);
        btn_up = 1'b1; run(10); btn_up = 1'b0; run(10);
        check_eq("sat_bright", int'(brightness), 15);
        btn_down = 1'b1; run(25); btn_down = 1'b0; run(15);
        check_eq("down_bright", int'(brightness), 13);

        // Both pressed together: no step.
        btn_up = 1'b1; btn_down = 1'b1; run(30);
        btn_up = 1'b0; btn_down = 1'b0; run(12);
        check_eq("both_bright", int'(brightness), 13);

        // Reset while repeating, button still held across release.
        btn_up = 1'b1;
        run(35);
        pulse_reset();
        run(15);
        btn_up = 1'b0;
        run(12);
        check_eq("post_rst_speed", int'(speed), 1);

        // Random phases of held button patterns with occasional bounce/reset.
        for (int ph = 0; ph < 80; ph++) begin
            int len;
            len = int'($urandom_range(1, 45));
            btn_mode = ($urandom_range(0, 5) == 0);
            btn_sel  = ($urandom_range(0, 5) == 0);
            btn_up   = ($urandom_range(0, 2) == 0);
            btn_down = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 30) == 0) btn_up = ~btn_up;
                run(1);
            end
            if ($urandom_range(0, 25) == 0) pulse_reset();
        end
        btn_mode = 1'b0; btn_sel = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        run(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cylon_ctrl_panel.md
CYLON_CTRL_PANEL -- requirements
Module: cylon_ctrl_panel

Interface
REQ-001 SHALL have parameter DEBOUNCE_CLKS, default 1_000_000, the stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter REPEAT_DELAY_CLKS, default 50_000_000, the hold time before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_RATE_CLKS, default 10_000_000, the cycles between auto-repeat steps.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port btn_mode, input, 1 bit: raw asynchronous button that advances the mode.
REQ-007 SHALL have port btn_sel, input, 1 bit: raw button that toggles the adjust target.
REQ-008 SHALL have port btn_up, input, 1 bit: raw button that increments the selected setting.
REQ-009 SHALL have port btn_down, input, 1 bit: raw button that decrements the selected setting.
REQ-010 SHALL have port mode, output, 2 bits: cylon mode (0 cylon, 1 R-to-L, 2 L-to-R, 3 count).
REQ-011 SHALL have port speed, output, 4 bits: speed shift value, 0..15.
REQ-012 SHALL have port brightness, output, 4 bits: brightness level, 0..15.
REQ-013 SHALL have port sel, output, 1 bit: adjust target (0 speed, 1 brightness).
REQ-014 SHALL have port changed, output, 1 bit: one-cycle pulse whenever mode, speed, brightness or sel changes value.

Function
REQ-015 SHALL pass each raw button through a 2-flop synchronizer before any other use.
REQ-016 SHALL give each button its own debouncer: the debounced level takes the synchronized level after that level has differed from the debounced level for DEBOUNCE_CLKS consecutive cycles; any bounce restarts the count.
REQ-017 SHALL treat a press as a 0->1 edge of the debounced level; releases produce no action.
REQ-018 SHALL apply the press action in the cycle after the debounced edge, giving a total latency of 2 + DEBOUNCE_CLKS + 1 cycles from a clean raw edge to the output update.
REQ-019 SHALL advance mode on a btn_mode press as 0->1->2->3->0, wrapping at 3.
REQ-020 SHALL toggle sel on a btn_sel press.
REQ-021 SHALL increment (up) or decrement (down) the setting chosen by sel; the result saturates at 15 and at 0, and a saturated press does not assert changed.
REQ-022 SHALL latch the adjust target at the press edge; a sel toggle during a hold does not redirect an active repeat.
REQ-023 SHALL implement the auto-repeat FSM with states IDLE, DELAY and REPEAT.
REQ-024 SHALL move IDLE->DELAY on an up or down press, applying one step.
REQ-025 SHALL move DELAY->REPEAT after REPEAT_DELAY_CLKS cycles of continuous hold, applying one step on entry.
REQ-026 SHALL apply one step every REPEAT_RATE_CLKS cycles while in REPEAT.
REQ-027 SHALL return to IDLE from any state when the held button's debounced level falls.
REQ-028 SHALL, when the debounced up and down levels are both high, apply no step and force IDLE; a new step needs a fresh press edge.
REQ-029 SHALL apply a mode or sel press in the same cycle as an up/down step both actions, with changed pulsing once.
REQ-030 SHALL size all counters to hold the largest parameter value; no counter wraps silently.

Reset
REQ-031 SHALL, on rst high, immediately force mode=0, speed=0, brightness=15, sel=0 and changed=0, with debounced levels 0, counters 0 and the FSM in IDLE.
REQ-032 SHALL, on rst assertion mid-hold or mid-debounce, abandon the operation; a button still held at release gives one press after a full debounce, never a spurious repeat.

Verification
(Run with DEBOUNCE_CLKS=4, REPEAT_DELAY_CLKS=20, REPEAT_RATE_CLKS=5.)
REQ-033 SHALL cover: reset release -> mode=0, speed=0, brightness=15, sel=0, changed=0.
REQ-034 SHALL cover: four clean btn_mode presses -> mode 1,2,3,0, each arriving 7 cycles after the raw edge with a one-cycle changed pulse.
REQ-035 SHALL cover: btn_up raw toggling every 2 cycles for 20 cycles and then low -> no output change.
REQ-036 SHALL cover: sel=0 with btn_up held 40 debounced cycles -> speed 0->1 at press, 2 at +20, then 3,4,5 at +25,+30,+35, and no further steps after release.
REQ-037 SHALL cover: sel toggled to 1, brightness=15, btn_up pressed -> brightness stays 15 and changed is not asserted; btn_down held 20 cycles -> brightness 14, then 13 on REPEAT entry.
REQ-038 SHALL cover: btn_up and btn_down debounced-high in the same cycle -> no change and FSM IDLE; rst pulsed mid-REPEAT -> all defaults restored at once.
